// File: rtl/aes_spi_pkg.sv
// rtl/aes_spi_pkg.sv - shared state encoding, frame-length helpers and FIPS-197 vectors for aes_spi_master
package aes_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_TX,
        ST_TURN,
        ST_RX,
        ST_HOLD,
        ST_DONE
    } state_t;

    function automatic int tx_bits_f(input int nk, input int pad_bits);
        return pad_bits + 128 + 32 * nk;
    endfunction

    function automatic int frame_edges_f(input int nk, input int pad_bits, input int turn_cycles);
        return tx_bits_f(nk, pad_bits) + turn_cycles + 128;
    endfunction

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

endpackage

// File: rtl/aes_spi_master_clk_gen.sv
// rtl/aes_spi_master_clk_gen.sv - SCLK divider emitting rise/fall strobes one clk ahead of the SCLK edge
module spi_clk_gen
    import aes_spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall
);

    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] r_cnt;
    logic             r_sclk;
    logic             w_tc;

    assign w_tc   = i_en && (r_cnt == DIV_W'(CLK_DIV - 1));
    assign o_rise = w_tc && !r_sclk;
    assign o_fall = w_tc && r_sclk;
    assign o_sclk = r_sclk;

    // Disabling parks SCLK low and restarts the half-period, so the first edge after enable is a rise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (!i_en) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (w_tc) begin
            r_cnt  <= '0;
            r_sclk <= !r_sclk;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/aes_spi_master.sv
// rtl/aes_spi_master.sv - SPI master: sends pad+block+key, turns around, captures 128-bit response.
// Optional AES_SPI_MASTER_FRAME_CNT_EN adds o_frame_count.
module aes_spi_master
    import aes_spi_pkg::*;
#(
    parameter int Nk          = 4,
    parameter int CLK_DIV     = 4,
    parameter int PAD_BITS    = 2,
    parameter int TURN_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [127:0]      i_data_in,
    input  logic [32*Nk-1:0]  i_key_in,
    output logic              o_busy,
    output logic              o_done,
    output logic [127:0]      o_data_out,
    output logic              o_sclk,
    output logic              o_cs,
    output logic              o_sdi,
    input  logic              i_sdo
`ifdef AES_SPI_MASTER_FRAME_CNT_EN
    ,
    output logic [15:0]       o_frame_count
`endif
);

    localparam int TX_BITS     = tx_bits_f(Nk, PAD_BITS);
    localparam int FRAME_EDGES = frame_edges_f(Nk, PAD_BITS, TURN_CYCLES);
    localparam int CNT_W       = $clog2(FRAME_EDGES + 1);
    localparam int HOLD_W      = $clog2(CLK_DIV);

    localparam logic [CNT_W-1:0] TX_LAST    = CNT_W'(TX_BITS - 1);
    localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TX_BITS + TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_EDGES);

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_rise_cnt;
    logic [TX_BITS-1:0]  r_tx;
    logic [127:0]        r_rx;
    logic [127:0]        r_data_out;
    logic                r_cs;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic                w_gen_en;
    logic                w_rise;
    logic                w_fall;
    logic                w_sclk;

    assign w_gen_en = (r_state == ST_SETUP) || (r_state == ST_TX) ||
                      (r_state == ST_TURN)  || (r_state == ST_RX);

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (w_gen_en),
        .o_sclk (w_sclk),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // r_rise_cnt holds the number of rises already issued, so "== N-1 on a rise" means rise N.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_next = ST_SETUP;
            ST_SETUP: if (w_rise) w_next = ST_TX;
            ST_TX:    if (w_rise && r_rise_cnt == TX_LAST)
                          w_next = (TURN_CYCLES == 0) ? ST_RX : ST_TURN;
            ST_TURN:  if (w_rise && r_rise_cnt == TURN_LAST) w_next = ST_RX;
            ST_RX:    if (w_fall && r_rise_cnt == FRAME_LAST) w_next = ST_HOLD;
            ST_HOLD:  if (r_hold_cnt == HOLD_W'(CLK_DIV - 1)) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_rise_cnt <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_data_out <= '0;
            r_cs       <= 1'b1;
            r_hold_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && i_start) begin
                r_tx       <= TX_BITS'({i_data_in, i_key_in});
                r_cs       <= 1'b0;
                r_rise_cnt <= '0;
            end
            if (w_rise)
                r_rise_cnt <= r_rise_cnt + CNT_W'(1);
            // Zeros shift in behind the payload, which keeps SDI low through turnaround and response.
            if (w_fall)
                r_tx <= {r_tx[TX_BITS-2:0], 1'b0};
            if (w_rise && r_state == ST_RX)
                r_rx <= {r_rx[126:0], i_sdo};
            r_hold_cnt <= (r_state == ST_HOLD) ? r_hold_cnt + HOLD_W'(1) : '0;
            if (r_state == ST_HOLD && w_next == ST_DONE) begin
                r_cs       <= 1'b1;
                r_data_out <= r_rx;
            end
        end
    end

    assign o_busy     = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign o_done     = (r_state == ST_DONE);
    assign o_data_out = r_data_out;
    assign o_sclk     = w_sclk;
    assign o_cs       = r_cs;
    assign o_sdi      = r_tx[TX_BITS-1];

`ifdef AES_SPI_MASTER_FRAME_CNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_frame_count <= '0;
        else if (r_state == ST_DONE)
            r_frame_count <= r_frame_count + 16'd1;
    end

    assign o_frame_count = r_frame_count;
`endif

endmodule

// File: doc/aes_spi_master.md
Name: aes_spi_master

Overview:
- Host-side SPI master that serialises one 128-bit block and one 32*Nk-bit key to the AES SPI target core, then deserialises the 128-bit result.
- Sits between the host/testbench register interface and the AES SPI target; drives its CS/SCLK/SDI and samples its SDO.
- One transfer per start pulse; the target is combinational-in-frame, so no handshake beyond frame timing.

Parameters:
- Nk, 4, key length in 32-bit words (4/6/8).
- CLK_DIV, 4, clk cycles per SCLK half-period (>=2).
- PAD_BITS, 2, dummy zero bits sent before data.
- TURN_CYCLES, 2, SCLK rising edges between last key bit and first response sample.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- data_in  in  128  block to transfer, MSB first
- key_in  in  32*Nk  key, MSB first
- busy  out  1  high from accepted start until done
- done  out  1  one-clk pulse when data_out is valid
- data_out  out  128  captured response, MSB = first received bit
- SCLK  out  1  serial clock, idle low
- CS  out  1  chip select, active low
- SDI  out  1  master-out serial data
- SDO  in  1  master-in serial data

Behaviour:
- Reset (async, any state): CS=1, SCLK=0, SDI=0, busy=0, done=0, data_out=0, FSM->IDLE, counters cleared. Mid-frame reset aborts the frame; no done.
- Internal divider: rise/fall strobes every CLK_DIV clks while active; SCLK toggles on strobes.
- Frame: PAD_BITS zeros + data_in[127:0] + key_in[32*Nk-1:0] = TX_BITS = PAD_BITS+128+32*Nk bits. SDI changes only when SCLK falls (first bit driven while CS asserts); target samples on SCLK rise.
- After TX_BITS rising edges: TURN_CYCLES rising edges with SDI=0, no capture.
- Response: bit k (k=0..127) sampled on rising edge TX_BITS+TURN_CYCLES+1+k; shifted into data_out LSB side (MSB first).
- Total rising edges per frame = TX_BITS+TURN_CYCLES+128 (388 for defaults).
- FSM:
  - IDLE: start=1 -> latch data_in/key_in into shift register, busy=1, CS=0, -> SETUP.
  - SETUP: wait one half-period (CS-to-first-edge), -> TX.
  - TX: count rises to TX_BITS -> TURN.
  - TURN: count TURN_CYCLES rises -> RX.
  - RX: 128 captures; after last capture, SCLK returns low -> HOLD.
  - HOLD: one half-period with SCLK=0, then CS=1 -> DONE.
  - DONE: done=1 one clk, data_out updated same cycle, busy=0 -> IDLE.
- start while busy ignored; start in the DONE cycle ignored.
- data_in/key_in changes after acceptance do not affect frame.
- data_out holds last value until next done; it is not written mid-frame (capture into a shadow register).
- CS stays low continuously for the whole frame; exactly one CS low pulse per transfer.

Optional Feature:
- AES_SPI_MASTER_FRAME_CNT_EN: adds output frame_count[15:0], reset 0, +1 on each done, wraps 65535->0. Without macro: port and counter absent, behaviour otherwise identical.

Decomposition:
- Package aes_spi_pkg: FSM state enum, TX_BITS/FRAME_EDGES localparam functions of Nk/PAD_BITS/TURN_CYCLES, FIPS-197 test-vector constants.
- One sub-module: spi_clk_gen (divider producing sclk_rise/sclk_fall strobes and SCLK level, enable input).

Test Plan:
- FIPS-197 AES-128 with the AES SPI target (encrypt): data 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> done once, data_out=69c4e0d86a7b0430d8cdb78070b4c55a.
- Frame timing, CLK_DIV=4, Nk=4: exactly 388 SCLK rises while CS=0, one CS low pulse, SDI stable across every rise, first two transmitted bits 0.
- Loopback model returning pattern a5a5...a5 on SDO in response window -> data_out=a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5; bits outside window ignored.
- start pulsed again at busy and at done cycle -> ignored; second start in IDLE -> second full frame.
- Assert rst at SCLK rise 200 -> CS=1, SCLK=0, busy=0 asynchronously, no done, data_out unchanged-from-reset 0; next start runs normal frame.
- With AES_SPI_MASTER_FRAME_CNT_EN and counter preloaded by 65535 frames (force) -> next done wraps frame_count to 0.
